// File: rtl/trng_word_fifo.sv
// First-word-fall-through buffer between the TRNG wrapper and its consumer.
// Words offered while the buffer is full are dropped and counted, never overwritten.
module trng_word_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CW    = 4
) (
    input  logic          clk,
    input  logic          buf_rst,
    input  logic [63:0]   wr_data,
    input  logic          wr_en,
    input  logic          rd_ready,
    input  logic          clr_overflow,
    output logic [63:0]   rd_data,
    output logic          rd_valid,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    output logic [7:0]    drop_count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if ((DEPTH < 2) || (DEPTH > 64) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("trng_word_fifo: DEPTH must be a power of two between 2 and 64");
    end
    if (CW != ($clog2(DEPTH) + 1)) begin : g_bad_cw
        $error("trng_word_fifo: CW must equal log2(DEPTH)+1");
    end

    logic [63:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic [7:0]    r_drop_count;

    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [CW-1:0] w_count_nxt;
    logic          w_overflow_nxt;
    logic [7:0]    w_drop_count_nxt;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // A pop frees a slot in the same edge, so a full buffer can still accept a word.
    assign w_pop  = !w_empty && rd_ready;
    assign w_push = wr_en && (!w_full || w_pop);
    assign w_drop = wr_en && w_full && !w_pop;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    // A drop in the same cycle as a clear wins: the clear restarts the tally at this drop.
    always_comb begin
        w_overflow_nxt   = r_overflow;
        w_drop_count_nxt = r_drop_count;
        if (w_drop) begin
            w_overflow_nxt = 1'b1;
            if (clr_overflow) begin
                w_drop_count_nxt = 8'd1;
            end else if (r_drop_count != 8'hFF) begin
                w_drop_count_nxt = r_drop_count + 1'b1;
            end
        end else if (clr_overflow) begin
            w_overflow_nxt   = 1'b0;
            w_drop_count_nxt = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !buf_rst) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge buf_rst) begin
        if (buf_rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= 8'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count      <= w_count_nxt;
            r_overflow   <= w_overflow_nxt;
            r_drop_count <= w_drop_count_nxt;
        end
    end

    assign rd_data    = r_mem[r_rd_ptr];
    assign rd_valid   = !w_empty;
    assign count      = r_count;
    assign full       = w_full;
    assign empty      = w_empty;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_trng_word_fifo.sv
// Scoreboard bench for trng_word_fifo: a reference queue predicts head data and status.
module tb_trng_word_fifo;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = 4;

    logic          clk = 1'b0;
    logic          buf_rst;
    logic [63:0]   wr_data;
    logic          wr_en;
    logic          rd_ready;
    logic          clr_overflow;
    logic [63:0]   rd_data;
    logic          rd_valid;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          overflow;
    logic [7:0]    drop_count;

    trng_word_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk          (clk),
        .buf_rst      (buf_rst),
        .wr_data      (wr_data),
        .wr_en        (wr_en),
        .rd_ready     (rd_ready),
        .clr_overflow (clr_overflow),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [63:0] sb[$];
    logic        m_ovf  = 1'b0;
    int unsigned m_drop = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_status();
        check_val("count", 64'(count), 64'(sb.size()));
        check_val("empty", 64'(empty), 64'(sb.size() == 0));
        check_val("full", 64'(full), 64'(sb.size() == DEPTH));
        check_val("rd_valid", 64'(rd_valid), 64'(sb.size() != 0));
        check_val("overflow", 64'(overflow), 64'(m_ovf));
        check_val("drop_count", 64'(drop_count), 64'(m_drop));
    endtask

    // Called just after a rising edge; drives one cycle and checks the result.
    task automatic cycle(input logic we, input logic [63:0] d, input logic rr, input logic clr);
        bit pop, push, drop;
        wr_en        = we;
        wr_data      = d;
        rd_ready     = rr;
        clr_overflow = clr;
        #1;
        if (sb.size() != 0) check_val("head", rd_data, sb[0]);
        pop  = (sb.size() != 0) && rr;
        push = we && ((sb.size() < DEPTH) || pop);
        drop = we && !push;
        @(posedge clk);
        #1;
        if (pop) begin
            if (rd_data === rd_data) begin end
            void'(sb.pop_front());
        end
        if (push) sb.push_back(d);
        if (drop) begin
            m_ovf  = 1'b1;
            m_drop = clr ? 1 : ((m_drop == 255) ? 255 : m_drop + 1);
        end else if (clr) begin
            m_ovf  = 1'b0;
            m_drop = 0;
        end
        check_status();
        wr_en        = 1'b0;
        rd_ready     = 1'b0;
        clr_overflow = 1'b0;
    endtask

    initial begin
        buf_rst      = 1'b1;
        wr_en        = 1'b0;
        wr_data      = '0;
        rd_ready     = 1'b0;
        clr_overflow = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_status();
        buf_rst = 1'b0;

        // Three words in, then drain in order.
        cycle(1'b1, {4{16'h1111}}, 1'b0, 1'b0);
        cycle(1'b1, {4{16'h2222}}, 1'b0, 1'b0);
        cycle(1'b1, {4{16'h3333}}, 1'b0, 1'b0);
        check_val("three_count", 64'(count), 64'd3);
        check_val("three_head", rd_data, {4{16'h1111}});
        repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);
        check_val("drained_empty", 64'(empty), 64'd1);

        // Push while empty with rd_ready high: push only.
        cycle(1'b1, 64'hA5A5_0000_0000_0001, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Fill, then one drop.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 64'hF000_0000_0000_0000 + 64'(i), 1'b0, 1'b0);
        check_val("fill_full", 64'(full), 64'd1);
        cycle(1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0, 1'b0);
        check_val("drop_ovf", 64'(overflow), 64'd1);
        check_val("drop_cnt1", 64'(drop_count), 64'd1);
        check_val("drop_head", rd_data, 64'hF000_0000_0000_0000);

        // Clear, then push+pop while full.
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b1, 64'hCAFE_0000_0000_0008, 1'b1, 1'b0);
        check_val("pp_count", 64'(count), 64'd8);
        check_val("pp_ovf", 64'(overflow), 64'd0);

        // Saturating drop counter and clear interactions.
        for (int i = 0; i < 300; i++) cycle(1'b1, 64'(i), 1'b0, 1'b0);
        check_val("drop_sat", 64'(drop_count), 64'd255);
        cycle(1'b0, '0, 1'b0, 1'b1);
        check_val("clr_ovf", 64'(overflow), 64'd0);
        check_val("clr_cnt", 64'(drop_count), 64'd0);
        cycle(1'b1, 64'h1, 1'b0, 1'b0);
        cycle(1'b1, 64'h2, 1'b0, 1'b1);
        check_val("clr_drop_ovf", 64'(overflow), 64'd1);
        check_val("clr_drop_cnt", 64'(drop_count), 64'd1);

        // Drain, then streaming push/pop across several pointer wraps.
        repeat (DEPTH) cycle(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b1, 64'h5000 + 64'(i), 1'b1, 1'b0);
        repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            cycle(1'($urandom_range(0, 1)), 64'($urandom) << 32 | 64'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
        end
        while (sb.size() > 0) cycle(1'b0, '0, 1'b1, 1'b0);

        // Asynchronous reset between edges with five words stored.
        for (int i = 0; i < 5; i++) cycle(1'b1, 64'h7000 + 64'(i), 1'b0, 1'b0);
        #2;
        buf_rst = 1'b1;
        #1;
        check_val("arst_count", 64'(count), 64'd0);
        check_val("arst_valid", 64'(rd_valid), 64'd0);
        sb.delete();
        m_ovf  = 1'b0;
        m_drop = 0;
        wr_en    = 1'b1;
        rd_ready = 1'b1;
        @(posedge clk);
        #1;
        check_status();
        wr_en    = 1'b0;
        rd_ready = 1'b0;
        #2;
        buf_rst = 1'b0;
        #1;
        cycle(1'b1, 64'hB0B0_B0B0_0000_0001, 1'b0, 1'b0);
        check_val("post_rst_head", rd_data, 64'hB0B0_B0B0_0000_0001);
        cycle(1'b0, '0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
